fetch_decode_skid: RTL

- Two-entry skid buffer forming the IF/ID boundary of the pipeline core.
- Accepts fetched instruction, PC and PC+4 from the fetch stage over a valid/ready handshake.
- Presents them to decode, which feeds the register file, control unit and immediate sign-extension logic.
- Provides full-throughput back-pressure without a combinational ready path, plus a decode flush for taken branches and jumps.

---
 rtl/fetch_decode_skid.sv | 85 ++++++++
 1 files changed

// File: rtl/fetch_decode_skid.sv
// fetch_decode_skid: two-entry IF/ID skid buffer with registered ready and decode flush
module fetch_decode_skid #(
  parameter int          XLEN      = 32,
  parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [31:0]     InstrF,
  input  logic [XLEN-1:0] PCF,
  input  logic [XLEN-1:0] PCPlus4F,
  input  logic            ValidF,
  output logic            ReadyF,
  output logic [31:0]     InstrD,
  output logic [XLEN-1:0] PCD,
  output logic [XLEN-1:0] PCPlus4D,
  output logic            ValidD,
  input  logic            ReadyD,
  input  logic            FlushD,
  output logic [1:0]      Count
);
  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;
  state_t            state_q;
  logic [31:0]       instr_q, skid_instr_q;
  logic [XLEN-1:0]   pc_q, pc4_q, skid_pc_q, skid_pc4_q;
  logic              fire_in, fire_out;
  assign ValidD   = state_q != EMPTY;
  assign ReadyF   = state_q != FULL;
  assign Count    = state_q;
  assign InstrD   = instr_q;
  assign PCD      = pc_q;
  assign PCPlus4D = pc4_q;
  assign fire_in  = ValidF & ReadyF;
  assign fire_out = ValidD & ReadyD;
  // occupancy FSM moving entries fetch -> main/skid -> decode; flush wins over every other event
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= EMPTY;
      instr_q      <= NOP_INSTR;
      pc_q         <= '0;
      pc4_q        <= '0;
      skid_instr_q <= NOP_INSTR;
      skid_pc_q    <= '0;
      skid_pc4_q   <= '0;
    end else if (FlushD) begin
      state_q      <= EMPTY;
      instr_q      <= NOP_INSTR;
      pc_q         <= '0;
      pc4_q        <= '0;
      skid_instr_q <= NOP_INSTR;
      skid_pc_q    <= '0;
      skid_pc4_q   <= '0;
    end else begin
      case (state_q)
        EMPTY: if (fire_in) begin
          state_q <= ONE;
          instr_q <= InstrF;
          pc_q    <= PCF;
          pc4_q   <= PCPlus4F;
        end
        ONE: if (fire_in && fire_out) begin
          instr_q <= InstrF;
          pc_q    <= PCF;
          pc4_q   <= PCPlus4F;
        end else if (fire_in) begin
          state_q      <= FULL;
          skid_instr_q <= InstrF;
          skid_pc_q    <= PCF;
          skid_pc4_q   <= PCPlus4F;
        end else if (fire_out) begin
          state_q <= EMPTY;
          instr_q <= NOP_INSTR;
          pc_q    <= '0;
          pc4_q   <= '0;
        end
        FULL: if (fire_out) begin
          state_q <= ONE;
          instr_q <= skid_instr_q;
          pc_q    <= skid_pc_q;
          pc4_q   <= skid_pc4_q;
        end
        default: state_q <= EMPTY;
      endcase
    end
  end
endmodule
